// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
// Computes (a - b) mod 2^N over N RUN cycles; diff/borrow update only on completion.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_d;
  logic          bin_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  diff_q;
  logic          borrow_q;
  logic          busy_q;
  logic          done_q;
  logic          bit_d;
  logic          bout_d;

  always_comb begin
    bit_d  = a_q[0] ^ b_q[0] ^ bin_q;
    bout_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    r_d    = {bit_d, r_q[N-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= {1'b0, a_q[N-1:1]};
          b_q   <= {1'b0, b_q[N-1:1]};
          r_q   <= r_d;
          bin_q <= bout_d;
          cnt_q <= cnt_q + 1'b1;
          // Final bit is folded in directly so diff is complete on the same edge.
          if (cnt_q == LAST) begin
            diff_q   <= r_d;
            borrow_q <= bout_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: N, default 8, operand width in bits (N >= 2).
REQ-002 clock  input  1  Rising-edge clock for all state.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 start  input  1  Request to begin one subtraction; sampled only in IDLE.
REQ-005 a  input  N  Minuend, unsigned; sampled on the edge that accepts start.
REQ-006 b  input  N  Subtrahend, unsigned; sampled on the edge that accepts start.
REQ-007 diff  output  N  Registered result (a - b) mod 2^N.
REQ-008 borrow  output  1  Registered final borrow-out; 1 iff a < b (unsigned).
REQ-009 busy  output  1  High while a subtraction is in progress (RUN state).
REQ-010 done  output  1  Single-cycle pulse marking diff/borrow as newly valid.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE with start=1: on that edge, a and b SHALL be loaded into internal N-bit shift registers, borrow-in cleared, bit counter cleared, next state RUN.
REQ-013 IDLE with start=0: the FSM SHALL remain in IDLE with internal registers unchanged.
REQ-014 RUN: each cycle, the LSBs ai, bi and borrow-in bin SHALL form d = ai ^ bi ^ bin and bout = (~ai & bi) | (~(ai ^ bi) & bin).
REQ-015 RUN: on each edge, the a and b registers SHALL shift right one bit (MSB filled with 0), d SHALL shift into the MSB of an internal result shift register, bin <= bout, counter increments.
REQ-016 RUN SHALL last exactly N cycles; on the edge where counter = N-1, next state DONE.
REQ-017 On that same edge, diff SHALL be loaded with the completed result register (incl. final bit) and borrow with the final bout.
REQ-018 DONE SHALL last exactly one cycle, with done=1, then go unconditionally to IDLE.
REQ-019 Latency: start accepted at edge k -> done high in the cycle after edge k+N (N+1 cycles after acceptance).
REQ-020 busy SHALL be 1 exactly in RUN; done exactly in DONE; never both high.
REQ-021 diff and borrow SHALL hold their values through RUN, DONE and IDLE until the next result load (REQ-017); they SHALL not change during a run.
REQ-022 start asserted in RUN or DONE SHALL be ignored, not queued; a and b changes after acceptance SHALL not affect the result.
REQ-023 start held high continuously SHALL yield back-to-back operations, one every N+2 cycles (IDLE, N x RUN, DONE).

Reset
REQ-024 reset=1 on a rising edge SHALL force IDLE, diff=0, borrow=0, busy=0, done=0, counter=0, bin=0 and clear internal shift registers.
REQ-025 reset SHALL take priority over start and over any state, including mid-RUN; the aborted operation SHALL produce no done pulse and no result update.
REQ-026 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-027 N=8, a=100, b=37, start 1 cycle -> busy 8 cycles, done 1 cycle at start edge+9, diff=63, borrow=0.
REQ-028 N=8, a=37, b=100 -> diff=193, borrow=1; a=0, b=1 -> diff=255, borrow=1; a=255, b=255 -> diff=0, borrow=0.
REQ-029 Start pulses during RUN and during DONE, a/b changed mid-run -> exactly one done pulse, result from originally sampled operands, diff unchanged until done.
REQ-030 reset asserted at RUN cycle 4 of a=200, b=1 -> next cycle IDLE, diff=0, borrow=0, no done; subsequent a=200, b=1 -> diff=199, borrow=0.
REQ-031 start held high for three operations (9-10, 10-9, 0-0) -> done every 10 cycles, results 255/1, 1/0, 0/0 (diff/borrow).
REQ-032 Randomized run of 1000 operand pairs against the reference model (a - b) mod 256 and (a < b), checking REQ-020 each cycle.
